// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, direct-mapped one-word-line I-cache, byte-wide miss fill, optional static predictor.
// Define IFU_STATIC_PREDICT_EN to enable JAL / backward-branch prediction.
module inst_fetch_unit #(
  parameter int          ADDR_WIDTH   = 17,
  parameter int          ICACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [7:0]            mem_din,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_out,
  output logic [31:0]           inst_pc,
  output logic                  inst_pred_taken,
  input  logic                  flush_in,
  input  logic [31:0]           flush_pc
);

  localparam int ICACHE_LINES = 2 ** ICACHE_IDX_W;
  localparam int TAG_W        = ADDR_WIDTH - ICACHE_IDX_W - 2;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]              state;
  logic [31:0]             pc;
  logic [1:0]              byte_cnt;
  logic [23:0]             line_buf;
  logic [ICACHE_LINES-1:0] valid;
  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];

  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit;
  logic [31:0]             hit_word;
  logic [ADDR_WIDTH-1:0]   line_base;
  logic                    fill_done;
  logic [31:0]             next_pc;
  logic                    pred_taken;

  assign idx       = pc[ICACHE_IDX_W+1:2];
  assign tag       = pc[ADDR_WIDTH-1:ICACHE_IDX_W+2];
  assign hit_word  = data_mem[idx];
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign line_base = {pc[ADDR_WIDTH-1:2], 2'b00};
  assign fill_done = (state == FILL) && mem_valid && (byte_cnt == 2'd3);

`ifdef IFU_STATIC_PREDICT_EN
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic        is_jal;
  logic        is_bwd_branch;

  assign imm_j = {{12{hit_word[31]}}, hit_word[19:12], hit_word[20], hit_word[30:21], 1'b0};
  assign imm_b = {{20{hit_word[31]}}, hit_word[7], hit_word[30:25], hit_word[11:8], 1'b0};
  assign is_jal        = (hit_word[6:0] == 7'b1101111);
  assign is_bwd_branch = (hit_word[6:0] == 7'b1100011) && hit_word[31];

  always_comb begin
    next_pc    = pc + 32'd4;
    pred_taken = 1'b0;
    if (is_jal) begin
      next_pc    = pc + imm_j;
      pred_taken = 1'b1;
    end else if (is_bwd_branch) begin
      next_pc    = pc + imm_b;
      pred_taken = 1'b1;
    end
  end
`else
  assign next_pc    = pc + 32'd4;
  assign pred_taken = 1'b0;
`endif

  // The line array is plain storage; only the valid bits need a reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in && fill_done) begin
      data_mem[idx] <= {mem_din, line_buf};
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc              <= RESET_PC;
      state           <= RUN;
      byte_cnt        <= 2'd0;
      line_buf        <= 24'd0;
      valid           <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      inst_valid      <= 1'b0;
      inst_out        <= 32'd0;
      inst_pc         <= 32'd0;
      inst_pred_taken <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc         <= flush_pc;
        inst_valid <= 1'b0;
        state      <= RUN;
        mem_req    <= 1'b0;
        byte_cnt   <= 2'd0;
      end else if (state == RUN) begin
        if (hit) begin
          if (!inst_valid || inst_ready) begin
            inst_valid      <= 1'b1;
            inst_out        <= hit_word;
            inst_pc         <= pc;
            inst_pred_taken <= pred_taken;
            pc              <= next_pc;
          end
        end else begin
          if (inst_valid && inst_ready) inst_valid <= 1'b0;
          state    <= FILL;
          byte_cnt <= 2'd0;
          mem_req  <= 1'b1;
          mem_addr <= line_base;
        end
      end else begin
        // The output slot keeps draining while the line is being assembled.
        if (inst_valid && inst_ready) inst_valid <= 1'b0;
        if (mem_valid) begin
          byte_cnt <= byte_cnt + 2'd1;
          case (byte_cnt)
            2'd0:    line_buf[7:0]   <= mem_din;
            2'd1:    line_buf[15:8]  <= mem_din;
            2'd2:    line_buf[23:16] <= mem_din;
            default: line_buf        <= line_buf;
          endcase
          if (byte_cnt == 2'd3) begin
            valid[idx] <= 1'b1;
            state      <= RUN;
            mem_req    <= 1'b0;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule
